// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM encoding, FIFO depth
// and the issue-credit rule shared by the datapath.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // A read may be issued only if every word already buffered or in flight,
    // plus the new one, still fits once this cycle's pop is accounted for.
    function automatic logic credit_ok(
        input logic [1:0] fifo_count,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] occ;
        occ = {1'b0, fifo_count} + {2'b00, inflight};
        return occ < (3'(FIFO_DEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/ram_d.sv
// Simple dual-port block RAM: one synchronous write port and one read port
// with a single registered read stage.
module ram_d #(
    parameter int addr_bits = 8,
    parameter int data_bits = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [addr_bits-1:0] waddr,
    input  logic [data_bits-1:0] wdata,
    input  logic                 re,
    input  logic [addr_bits-1:0] raddr,
    output logic [data_bits-1:0] rdata
);

    logic [data_bits-1:0] r_mem [0:(1<<addr_bits)-1];
    logic [data_bits-1:0] r_rdata;

    // Write port and registered read port; storage carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/ram_stream_reader_stream_fifo2.sv
// Two-entry register FIFO holding {last, data} words between the RAM read
// stage and the output stream; the head is visible whenever count != 0.
module stream_fifo2 #(
    parameter int width = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [1:0]       count,
    output logic [width-1:0] head
);

    logic [width-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Storage, pointers and occupancy; the producer never pushes when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read engine: walks a RAM address range, absorbs the one-cycle read
// latency and presents the words as a back-pressured valid/ready stream.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int addr_bits = 8,
    parameter int data_bits = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [addr_bits-1:0] base_addr,
    input  logic [addr_bits:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_en,
    output logic [addr_bits-1:0] ram_addr,
    input  logic [data_bits-1:0] ram_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [data_bits-1:0] m_data,
    output logic                 m_last
);

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [addr_bits-1:0] r_addr;
    logic [addr_bits:0]   r_rem_issue;
    logic [addr_bits:0]   r_rem_accept;
    logic                 r_inflight;
    logic                 r_inflight_last;

    logic [1:0]           w_fifo_count;
    logic [data_bits:0]   w_head;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_launch;

    assign w_launch = start & ~r_busy;
    assign w_pop    = m_valid & m_ready;
    // Issue is combinational so a returning m_ready frees credit in the same cycle.
    assign w_issue  = (r_state == ST_RUN) &&
                      (r_rem_issue != {(addr_bits+1){1'b0}}) &&
                      credit_ok(w_fifo_count, r_inflight, w_pop);

    assign busy     = r_busy;
    assign done     = r_done;
    assign ram_en   = w_issue;
    assign ram_addr = r_addr;
    assign m_valid  = (w_fifo_count != 2'd0);
    assign m_data   = w_head[data_bits-1:0];
    assign m_last   = w_head[data_bits];

    // Address and remaining-issue/accept counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_rem_issue  <= '0;
            r_rem_accept <= '0;
        end else if (w_launch) begin
            r_addr       <= base_addr;
            r_rem_issue  <= len;
            r_rem_accept <= len;
        end else begin
            if (w_issue) begin
                r_addr      <= r_addr + addr_bits'(1'b1);
                r_rem_issue <= r_rem_issue - (addr_bits+1)'(1'b1);
            end
            if (w_pop) begin
                r_rem_accept <= r_rem_accept - (addr_bits+1)'(1'b1);
            end
        end
    end

    // Tracks the read whose data appears on ram_dout this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rem_issue == (addr_bits+1)'(1'b1));
        end
    end

    stream_fifo2 #(
        .width(data_bits + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_inflight),
        .pop   (w_pop),
        .din   ({r_inflight_last, ram_dout}),
        .count (w_fifo_count),
        .head  (w_head)
    );

    // Control FSM; a zero-length burst spends one busy cycle in FIN before done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_launch) begin
                        r_busy  <= 1'b1;
                        r_state <= (len == {(addr_bits+1){1'b0}}) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_done <= 1'b0;
                    if (w_pop && m_last) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_done <= 1'b0;
                        if (w_launch) begin
                            r_busy  <= 1'b1;
                            r_state <= (len == {(addr_bits+1){1'b0}}) ? ST_FIN : ST_RUN;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
